// File: rtl/add_sub_inv_if.sv
// Request/result bus of add_sub_inv; master is the requester/consumer, slave is the block.
// All signals are named as seen from the inverse unit.
interface add_sub_inv_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   y_in;
    logic [WIDTH-1:0] b_in;
    logic             s1;
    logic             s0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a_out;
    logic             range_err;
    logic             mode_err;

    modport master (
        output in_valid, y_in, b_in, s1, s0, out_ready,
        input  in_ready, out_valid, a_out, range_err, mode_err
    );

    modport slave (
        input  in_valid, y_in, b_in, s1, s0, out_ready,
        output in_ready, out_valid, a_out, range_err, mode_err
    );
endinterface

// File: rtl/add_sub_inv.sv
// add_sub_inv: recovers operand A of the add/sub/xor datapath from Y, B and mode, LSB first (ADDSUB_INV_FAST_EN: one-shot compute).
// Latency: WIDTH+1 RUN cycles after accept, out_valid 10 cycles counting the accept cycle (fast build: next cycle).
// Backpressure: result held in DONE until out_ready; in_ready low from accept until the cycle after the result handshake.
module add_sub_inv #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    add_sub_inv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {
        M_ADD = 2'b00,
        M_SUB = 2'b01,
        M_XOR = 2'b10,
        M_RSV = 2'b11
    } mode_t;

    state_t           state_q, state_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] a_q;
    logic             range_err_q;
    logic             mode_err_q;
    logic             accept;
    mode_t            req_mode;

    // in_ready_q only rises while IDLE, so it alone qualifies an accept
    assign accept   = bus.in_valid & in_ready_q;
    assign req_mode = mode_t'({bus.s1, bus.s0});

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.a_out     = a_q;
    assign bus.range_err = range_err_q;
    assign bus.mode_err  = mode_err_q;

`ifdef ADDSUB_INV_FAST_EN
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] res;

    always_comb begin
        b_ext = {bus.b_in[WIDTH-1], bus.b_in};
        res   = '0;
        unique case (req_mode)
            M_ADD:   res = bus.y_in - b_ext;
            M_SUB:   res = bus.y_in + b_ext;
            default: res = bus.y_in ^ b_ext;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            range_err_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else if (accept) begin
            a_q         <= res[WIDTH-1:0];
            range_err_q <= res[WIDTH] ^ res[WIDTH-1];
            mode_err_q  <= (req_mode == M_RSV);
        end
    end
`else
    localparam int IDX_W = $clog2(WIDTH + 1);

    logic [WIDTH:0]   y_q;
    logic [WIDTH:0]   b_q;
    mode_t            mode_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] acc_q;
    logic             xor_mode;
    logic             b_eff;
    logic             r_bit;
    logic             c_next;
    logic             last_bit;

    // One full-adder cell; subtracting B is Y + ~B with the carry seeded to 1
    always_comb begin
        xor_mode = (mode_q == M_XOR) || (mode_q == M_RSV);
        b_eff    = (mode_q == M_ADD) ? ~b_q[0] : b_q[0];
        r_bit    = xor_mode ? (y_q[0] ^ b_q[0]) : (y_q[0] ^ b_eff ^ carry_q);
        c_next   = (y_q[0] & b_eff) | (y_q[0] & carry_q) | (b_eff & carry_q);
        last_bit = (idx_q == IDX_W'(WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            b_q         <= '0;
            mode_q      <= M_ADD;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            range_err_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else if (accept) begin
            y_q     <= bus.y_in;
            b_q     <= {bus.b_in[WIDTH-1], bus.b_in};
            mode_q  <= req_mode;
            carry_q <= (req_mode == M_ADD);
            idx_q   <= '0;
            acc_q   <= '0;
        end else if (state_q == RUN) begin
            y_q     <= y_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= c_next;
            idx_q   <= idx_q + IDX_W'(1);
            if (last_bit) begin
                // In xor mode B is sign-extended, so this reduces to y[WIDTH]^y[WIDTH-1]
                a_q         <= acc_q;
                range_err_q <= r_bit ^ acc_q[WIDTH-1];
                mode_err_q  <= (mode_q == M_RSV);
            end else begin
                acc_q <= {r_bit, acc_q[WIDTH-1:1]};
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
`ifdef ADDSUB_INV_FAST_EN
                if (accept) state_d = DONE;
`else
                if (accept) state_d = RUN;
`endif
            end
            RUN: begin
`ifndef ADDSUB_INV_FAST_EN
                if (last_bit) state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
        end
    end
endmodule
